// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator instruction sequencer: FSM state
// encoding, control opcodes and the control-opcode classifier.
package acc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    // Control opcodes live in the top sixteen codes and are executed by the
    // sequencer itself; they never reach the ALU.
    localparam logic [7:0] OPC_NOP  = 8'hF0;
    localparam logic [7:0] OPC_JMP  = 8'hF1;
    localparam logic [7:0] OPC_JZ   = 8'hF2;
    localparam logic [7:0] OPC_JNZ  = 8'hF3;
    localparam logic [7:0] OPC_HALT = 8'hFF;

    localparam logic [3:0] CTRL_PREFIX = 4'hF;

    // True for any opcode in the reserved control range 8'hF0..8'hFF.
    function automatic logic is_ctrl(input logic [7:0] op);
        return (op[7:4] == CTRL_PREFIX);
    endfunction

endpackage

// File: rtl/acc_sequencer.sv
// Instruction sequencer for the ALU + accumulator datapath. Fetches words
// from a synchronous program memory (one cycle read latency), decodes them
// and either forwards an ALU opcode with a one-cycle accumulator enable or
// executes jump / conditional jump / halt locally. Three cycles per
// instruction: FETCH, WAIT, EXEC.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 8,
    parameter int PC_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    output logic [PC_W-1:0]        pm_addr,
    output logic                   pm_en,
    input  logic [OP_W+WIDTH-1:0]  pm_data,
    output logic [OP_W-1:0]        alu_op,
    output logic [WIDTH-1:0]       alu_in,
    output logic                   acc_ce,
    input  logic                   acc_zero,
    output logic                   halted,
    output logic                   busy
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PC_W-1:0]         r_pc;
    logic [PC_W-1:0]         w_pc_next;
    logic [OP_W+WIDTH-1:0]   r_ir;

    logic [OP_W-1:0]         w_opcode;
    logic [WIDTH-1:0]        w_operand;
    logic [PC_W-1:0]         w_target;
    logic [PC_W-1:0]         w_pc_inc;
    logic                    w_ctrl;

    // Instruction fields; the jump target is the operand truncated to the
    // program counter width, and pc+1 wraps naturally at 2**PC_W.
    assign w_opcode  = r_ir[OP_W+WIDTH-1:WIDTH];
    assign w_operand = r_ir[WIDTH-1:0];
    assign w_target  = w_operand[PC_W-1:0];
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_ctrl    = is_ctrl(w_opcode);

    // The datapath sees the instruction register directly, so op/in stay
    // stable from EXEC until the next WAIT reloads the register.
    assign alu_op  = w_opcode;
    assign alu_in  = w_operand;
    assign pm_addr = r_pc;

    // State register, program counter and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == WAIT) begin
                r_ir <= pm_data;
            end
        end
    end

    // Next-state and next-pc decode. acc_zero is only consulted in EXEC; the
    // previous ALU write committed at least two cycles earlier.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                w_state_next = EXEC;
            end
            EXEC: begin
                w_state_next = FETCH;
                if (w_ctrl) begin
                    case (w_opcode)
                        OPC_JMP:  w_pc_next = w_target;
                        OPC_JZ:   w_pc_next = acc_zero ? w_target : w_pc_inc;
                        OPC_JNZ:  w_pc_next = acc_zero ? w_pc_inc : w_target;
                        OPC_HALT: w_state_next = HALT;
                        // NOP and the unassigned reserved codes just advance.
                        default:  w_pc_next = w_pc_inc;
                    endcase
                end else begin
                    w_pc_next = w_pc_inc;
                end
            end
            HALT: begin
                // pc still points at the HALT word; resume past it.
                if (run) begin
                    w_state_next = FETCH;
                    w_pc_next    = w_pc_inc;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Moore-style outputs plus the accumulator enable, which is combinational
    // from state so an asynchronous reset kills it immediately.
    always_comb begin
        pm_en  = (r_state == FETCH);
        busy   = (r_state == FETCH) || (r_state == WAIT) || (r_state == EXEC);
        halted = (r_state == HALT);
        acc_ce = (r_state == EXEC) && !w_ctrl;
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: behavioural program ROM and accumulator datapath,
// with a scoreboard of expected fetch addresses and ALU words.
module tb_acc_sequencer;
    import acc_seq_pkg::*;

    localparam int WIDTH = 16;
    localparam int OP_W  = 8;
    localparam int PC_W  = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  run;
    logic [PC_W-1:0]       pm_addr;
    logic                  pm_en;
    logic [OP_W+WIDTH-1:0] pm_data;
    logic [OP_W-1:0]       alu_op;
    logic [WIDTH-1:0]      alu_in;
    logic                  acc_ce;
    logic                  acc_zero;
    logic                  halted;
    logic                  busy;

    acc_sequencer #(.WIDTH(WIDTH), .OP_W(OP_W), .PC_W(PC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .pm_addr  (pm_addr),
        .pm_en    (pm_en),
        .pm_data  (pm_data),
        .alu_op   (alu_op),
        .alu_in   (alu_in),
        .acc_ce   (acc_ce),
        .acc_zero (acc_zero),
        .halted   (halted),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous ROM.
    logic [23:0] rom [0:255];
    always @(posedge clk) begin
        if (pm_en) pm_data <= rom[pm_addr];
    end

    // Behavioural datapath: 01 add, 02 load, 03 subtract.
    logic [15:0] acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (acc_ce) begin
            case (alu_op)
                8'h01:   acc <= acc + alu_in;
                8'h02:   acc <= alu_in;
                8'h03:   acc <= acc - alu_in;
                default: acc <= acc;
            endcase
        end
    end
    assign acc_zero = (acc == 16'h0000);

    typedef struct {
        int          cyc;
        logic [23:0] word;
    } alu_exp_t;

    int       exp_fetch[$];
    alu_exp_t exp_alu[$];
    int       n_checks = 0;
    int       n_err    = 0;
    int       cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [23:0] w(input logic [7:0] op, input logic [15:0] d);
        return {op, d};
    endfunction

    function automatic alu_exp_t ae(input int c, input logic [23:0] wd);
        alu_exp_t e;
        e.cyc  = c;
        e.word = wd;
        return e;
    endfunction

    // One clock; sample just after the edge and score any fetch / ALU event.
    task automatic step();
        int       a;
        alu_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (pm_en) begin
            $display("cyc=%0d fetch addr=0x%02h", cyc, pm_addr);
            if (exp_fetch.size() > 0) begin
                a = exp_fetch.pop_front();
                chk("fetch_addr", 32'(pm_addr), 32'(a));
            end else begin
                chk("fetch_extra", 32'(pm_en), 32'(0));
            end
        end
        if (acc_ce) begin
            $display("cyc=%0d alu op=0x%02h in=0x%04h", cyc, alu_op, alu_in);
            if (exp_alu.size() > 0) begin
                e = exp_alu.pop_front();
                chk("alu_word", 32'({alu_op, alu_in}), 32'(e.word));
                if (e.cyc >= 0) chk("acc_ce_cycle", 32'(cyc), 32'(e.cyc));
            end else begin
                chk("acc_ce_extra", 32'(acc_ce), 32'(0));
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b1;
        #1;
        for (int i = 0; i < 256; i++) rom[i] = w(OPC_HALT, 16'h0000);
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        cyc   = 0;
        rst_n = 1'b1;
        run   = 1'b1;
        step();
        run   = 1'b0;
    endtask

    task automatic run_until_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) step();
        chk("halt_reached", 32'(halted), 32'(1));
    endtask

    task automatic drain();
        chk("fetch_q_left", 32'(exp_fetch.size()), 32'(0));
        chk("alu_q_left", 32'(exp_alu.size()), 32'(0));
        exp_fetch.delete();
        exp_alu.delete();
    endtask

    task automatic jump_case(input logic [7:0] jop, input logic [15:0] val, input logic taken);
        do_reset();
        rom[0] = w(8'h02, val);
        rom[1] = w(jop, 16'h0010);
        exp_fetch.push_back(0);
        exp_fetch.push_back(1);
        exp_fetch.push_back(taken ? 16 : 2);
        exp_alu.push_back(ae(3, w(8'h02, val)));
        start();
        run_until_halt(40);
        chk("jump_pc", 32'(pm_addr), taken ? 32'h10 : 32'h2);
        drain();
    endtask

    initial begin
        rst_n   = 1'b0;
        run     = 1'b0;

        // Reset state held with run=1.
        do_reset();
        chk("rst_alu_op", 32'(alu_op), 32'(0));
        chk("rst_alu_in", 32'(alu_in), 32'(0));
        chk("rst_acc_ce", 32'(acc_ce), 32'(0));
        chk("rst_pm_en", 32'(pm_en), 32'(0));
        chk("rst_pm_addr", 32'(pm_addr), 32'(0));
        chk("rst_halted", 32'(halted), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));

        // Straight line: add 5, add 3, halt.
        rom[0] = w(8'h01, 16'h0005);
        rom[1] = w(8'h01, 16'h0003);
        rom[2] = w(OPC_HALT, 16'h0000);
        exp_fetch = '{0, 1, 2};
        exp_alu.push_back(ae(3, w(8'h01, 16'h0005)));
        exp_alu.push_back(ae(6, w(8'h01, 16'h0003)));
        start();
        chk("release_busy", 32'(busy), 32'(1));
        run_until_halt(40);
        chk("halt_pc", 32'(pm_addr), 32'(2));
        chk("halt_busy", 32'(busy), 32'(0));
        chk("acc_sum", 32'(acc), 32'(8));
        drain();

        // Resume: stay halted with run low, then resume at HALT address + 1.
        repeat (3) step();
        chk("halt_hold", 32'(halted), 32'(1));
        exp_fetch.push_back(3);
        run = 1'b1;
        step();
        chk("resume_busy", 32'(busy), 32'(1));
        run = 1'b0;
        run_until_halt(20);
        chk("resume_halt_pc", 32'(pm_addr), 32'(3));
        drain();

        // Conditional jumps, taken and not taken.
        jump_case(OPC_JZ,  16'h0000, 1'b1);
        jump_case(OPC_JZ,  16'h0001, 1'b0);
        jump_case(OPC_JNZ, 16'h0000, 1'b0);
        jump_case(OPC_JNZ, 16'h0001, 1'b1);

        // Wrap: JMP 0xFF, NOP at 0xFF -> back to 0x00.
        do_reset();
        rom[0]   = w(OPC_JMP, 16'h00FF);
        rom[255] = w(OPC_NOP, 16'h0000);
        exp_fetch = '{0, 255, 0};
        start();
        repeat (8) step();
        drain();

        // Jump target truncated to the pc width.
        do_reset();
        rom[0] = w(OPC_JMP, 16'h1234);
        exp_fetch = '{0, 8'h34};
        start();
        run_until_halt(40);
        chk("trunc_pc", 32'(pm_addr), 32'h34);
        drain();

        // Reset during EXEC of an ALU op.
        do_reset();
        rom[0] = w(8'h01, 16'h0005);
        exp_fetch.push_back(0);
        exp_alu.push_back(ae(3, w(8'h01, 16'h0005)));
        start();
        step();
        step();
        chk("exec_ce", 32'(acc_ce), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_ce", 32'(acc_ce), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        drain();
        do_reset();
        rom[0] = w(8'h01, 16'h0005);
        exp_fetch = '{0, 1};
        exp_alu.push_back(ae(3, w(8'h01, 16'h0005)));
        start();
        repeat (3) step();
        chk("refetch_acc", 32'(acc), 32'(5));
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
